// File: rtl/niosii_system_st_symbol_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : niosII_system_st_pkg
// Description : Shared defaults and lane helper for the ST symbol packer.
// Revision    : 1.0 - initial release
// ============================================================================
package niosII_system_st_pkg;

    localparam int c_symbol_width = 8;
    localparam int c_out_symbols  = 4;
    localparam int c_empty_width  = $clog2(c_out_symbols);

    // Lane 0 occupies the most significant symbol of a packed beat.
    function automatic int lane_lsb(input int lane, input int sym_w, input int n_sym);
        return (n_sym - 1 - lane) * sym_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/niosii_system_st_symbol_packer_if.sv
`default_nettype none
// ============================================================================
// Interface   : niosii_system_st_symbol_packer_if
// Description : Narrow input stream plus wide packed output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface niosii_system_st_symbol_packer_if
    import niosII_system_st_pkg::*;
#(
    parameter int SYMBOL_WIDTH = c_symbol_width,
    parameter int OUT_SYMBOLS  = c_out_symbols,
    parameter int EMPTY_WIDTH  = c_empty_width
);
    logic [SYMBOL_WIDTH-1:0]             in_data;
    logic                                in_valid;
    logic                                in_ready;
    logic                                in_startofpacket;
    logic                                in_endofpacket;
    logic [SYMBOL_WIDTH*OUT_SYMBOLS-1:0] out_data;
    logic                                out_valid;
    logic                                out_ready;
    logic                                out_startofpacket;
    logic                                out_endofpacket;
    logic [EMPTY_WIDTH-1:0]              out_empty;
    logic                                protocol_error;

    modport master (
        output in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
               out_empty, protocol_error
    );

    modport slave (
        input  in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
               out_empty, protocol_error
    );
endinterface
`default_nettype wire

// File: rtl/niosii_system_st_symbol_packer_outreg.sv
`default_nettype none
// ============================================================================
// Module      : niosII_system_st_packer_outreg
// Description : Single-entry output beat register with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module niosII_system_st_packer_outreg
    import niosII_system_st_pkg::*;
#(
    parameter int DATA_WIDTH  = c_symbol_width * c_out_symbols,
    parameter int EMPTY_WIDTH = c_empty_width
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_sop,
    input  logic                   i_eop,
    input  logic [EMPTY_WIDTH-1:0] i_empty,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic [EMPTY_WIDTH-1:0] o_empty
);
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_sop;
    logic                   r_eop;
    logic [EMPTY_WIDTH-1:0] r_empty;

    // A load is only offered when the register is free or draining, so the
    // fields hold naturally while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
            r_empty <= i_empty;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
    assign o_empty = r_empty;
endmodule
`default_nettype wire

// File: rtl/niosii_system_st_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module      : niosii_system_st_symbol_packer
// Description : Packs one-symbol input beats into OUT_SYMBOLS-symbol beats.
// Revision    : 1.0 - initial release
// ============================================================================
module niosii_system_st_symbol_packer
    import niosII_system_st_pkg::*;
#(
    parameter int SYMBOL_WIDTH = c_symbol_width,
    parameter int OUT_SYMBOLS  = c_out_symbols,
    parameter int EMPTY_WIDTH  = c_empty_width
) (
    input  logic                           clk,
    input  logic                           reset_n,
    niosii_system_st_symbol_packer_if.slave st
);
    localparam int                     c_data_w    = SYMBOL_WIDTH * OUT_SYMBOLS;
    localparam logic [EMPTY_WIDTH-1:0] c_last_lane = EMPTY_WIDTH'(OUT_SYMBOLS - 1);

    logic [EMPTY_WIDTH-1:0] r_count;
    logic                   r_sop_pending;
    logic                   r_ready_en;
    logic                   r_protocol_error;
    logic [c_data_w-1:0]    r_acc;

    logic [c_data_w-1:0]    w_beat;
    logic [EMPTY_WIDTH-1:0] w_lane;
    logic [EMPTY_WIDTH-1:0] w_empty;
    logic                   w_out_valid;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_mid_sop;
    logic                   w_complete;
    logic                   w_sop_eff;

    assign w_in_ready = r_ready_en && (!w_out_valid || st.out_ready);
    assign w_accept   = st.in_valid && w_in_ready;
    // An SOP landing mid-beat restarts the beat at lane 0, dropping the partial.
    assign w_mid_sop  = st.in_startofpacket && (r_count != '0);
    assign w_lane     = w_mid_sop ? '0 : r_count;
    assign w_complete = (w_lane == c_last_lane) || st.in_endofpacket;
    assign w_sop_eff  = r_sop_pending || st.in_startofpacket;
    assign w_empty    = st.in_endofpacket ? (c_last_lane - w_lane) : '0;

    for (genvar i = 0; i < OUT_SYMBOLS; i++) begin : g_lane
        localparam int c_lsb = lane_lsb(i, SYMBOL_WIDTH, OUT_SYMBOLS);
        assign w_beat[c_lsb +: SYMBOL_WIDTH] =
            (EMPTY_WIDTH'(i) == w_lane) ? st.in_data :
            (EMPTY_WIDTH'(i) <  w_lane) ? r_acc[c_lsb +: SYMBOL_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count          <= '0;
            r_sop_pending    <= 1'b0;
            r_ready_en       <= 1'b0;
            r_protocol_error <= 1'b0;
            r_acc            <= '0;
        end else begin
            r_ready_en       <= 1'b1;
            r_protocol_error <= w_accept && w_mid_sop;
            if (w_accept) begin
                r_acc <= w_beat;
                if (w_complete) begin
                    r_count       <= '0;
                    r_sop_pending <= 1'b0;
                end else begin
                    r_count       <= w_lane + 1'b1;
                    r_sop_pending <= w_sop_eff;
                end
            end
        end
    end

    niosII_system_st_packer_outreg #(
        .DATA_WIDTH  (c_data_w),
        .EMPTY_WIDTH (EMPTY_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept && w_complete),
        .i_data  (w_beat),
        .i_sop   (w_sop_eff),
        .i_eop   (st.in_endofpacket),
        .i_empty (w_empty),
        .i_ready (st.out_ready),
        .o_valid (w_out_valid),
        .o_data  (st.out_data),
        .o_sop   (st.out_startofpacket),
        .o_eop   (st.out_endofpacket),
        .o_empty (st.out_empty)
    );

    assign st.out_valid      = w_out_valid;
    assign st.in_ready       = w_in_ready;
    assign st.protocol_error = r_protocol_error;
endmodule
`default_nettype wire
